// File: rtl/main_data_router.sv
// Main-data router: drops stale reservoir bits, then steers FIFO bits to the
// scalefactor parser and Huffman decoder for each granule/channel in turn.
module main_data_router #(
    parameter int NGR     = 2,
    parameter int NCH     = 2,
    parameter int LEN_W   = 12,
    parameter int CNT_W   = 16,
    parameter int BEGIN_W = 9,
    localparam int GR_W   = (NGR > 1) ? $clog2(NGR) : 1,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         si_valid,
    input  logic [BEGIN_W-1:0]           main_data_begin,
    input  logic [NGR*NCH*LEN_W-1:0]     part2_3_length,
    input  logic                         mono,
    input  logic                         lsf,
    input  logic [CNT_W-1:0]             fifo_count,
    input  logic                         fifo_dout_v,
    input  logic                         sf_done,
    output logic                         fifo_rd,
    output logic                         sf_flag,
    output logic                         hf_flag,
    output logic [GR_W-1:0]              gr,
    output logic [CH_W-1:0]              ch,
    output logic                         frame_done,
    output logic [2:0]                   err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DISCARD,
        S_SF,
        S_HF,
        S_NEXT
    } state_t;

    state_t                     state_q, state_d;
    logic [BEGIN_W-1:0]         mdb_q, mdb_d;
    logic [NGR*NCH*LEN_W-1:0]   p23_q, p23_d;
    logic                       mono_q, mono_d;
    logic                       lsf_q, lsf_d;
    logic [CNT_W-1:0]           discard_q, discard_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CNT_W-1:0]           rem_q, rem_d;
    logic [GR_W-1:0]            gr_q, gr_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic                       sf_flag_q, sf_flag_d;
    logic                       hf_flag_q, hf_flag_d;
    logic                       frame_done_q, frame_done_d;
    logic [2:0]                 err_q, err_d;

    logic                       take;
    logic [CNT_W-1:0]           cnt_inc;
    logic [CNT_W-1:0]           begin_bits;
    logic [LEN_W-1:0]           len_cur;
    logic [CNT_W-1:0]           len_ext;

    // part2_3_length lookup for one (gr, ch) pair.
    function automatic logic [LEN_W-1:0] len_of(
        input logic [GR_W-1:0]            g_i,
        input logic [CH_W-1:0]            c_i,
        input logic [NGR*NCH*LEN_W-1:0]   tbl
    );
        len_of = '0;
        for (int g = 0; g < NGR; g++) begin
            for (int c = 0; c < NCH; c++) begin
                if (g_i == GR_W'(g) && c_i == CH_W'(c)) begin
                    len_of = tbl[(g*NCH+c)*LEN_W +: LEN_W];
                end
            end
        end
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fifo_rd = 1'b0;
        case (state_q)
            S_DISCARD: fifo_rd = fifo_dout_v;
            S_SF:      fifo_rd = sf_flag_q & fifo_dout_v & ~sf_done;
            S_HF:      fifo_rd = fifo_dout_v;
            default:   fifo_rd = 1'b0;
        endcase
    end

    assign take       = fifo_rd & fifo_dout_v;
    assign cnt_inc    = cnt_q + CNT_W'(take);
    assign begin_bits = CNT_W'({mdb_q, 3'b000});
    assign len_cur    = len_of(gr_q, ch_q, p23_q);
    assign len_ext    = CNT_W'(len_cur);

    always_comb begin
        state_d      = state_q;
        mdb_d        = mdb_q;
        p23_d        = p23_q;
        mono_d       = mono_q;
        lsf_d        = lsf_q;
        discard_d    = discard_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        gr_d         = gr_q;
        ch_d         = ch_q;
        err_d        = err_q;
        frame_done_d = 1'b0;

        if (si_valid && state_q != S_IDLE) begin
            err_d[2] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (si_valid) begin
                    mdb_d   = main_data_begin;
                    p23_d   = part2_3_length;
                    mono_d  = mono;
                    lsf_d   = lsf;
                    gr_d    = '0;
                    ch_d    = '0;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                gr_d  = '0;
                ch_d  = '0;
                cnt_d = '0;
                if (fifo_count < begin_bits) begin
                    err_d[0]  = 1'b1;
                    discard_d = '0;
                    state_d   = S_SF;
                end else begin
                    discard_d = fifo_count - begin_bits;
                    state_d   = (fifo_count == begin_bits) ? S_SF : S_DISCARD;
                end
            end

            S_DISCARD: begin
                cnt_d = cnt_inc;
                if (cnt_inc == discard_q) begin
                    cnt_d   = '0;
                    state_d = S_SF;
                end
            end

            S_SF: begin
                if (len_cur == '0) begin
                    state_d = S_NEXT;
                end else if (sf_done) begin
                    cnt_d = '0;
                    // Overrun is checked first so the unsigned subtraction never wraps.
                    if (cnt_q > len_ext) begin
                        err_d[1] = 1'b1;
                        rem_d    = '0;
                        state_d  = S_NEXT;
                    end else begin
                        rem_d   = len_ext - cnt_q;
                        state_d = (len_ext != cnt_q) ? S_HF : S_NEXT;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_HF: begin
                if (take) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_NEXT;
                    end
                end
            end

            S_NEXT: begin
                if (!mono_q && ch_q != CH_W'(NCH-1)) begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_SF;
                end else if (!lsf_q && gr_q != GR_W'(NGR-1)) begin
                    ch_d    = '0;
                    gr_d    = gr_q + GR_W'(1);
                    state_d = S_SF;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Flags are registered views of the state being entered; a zero-length entry never raises sf_flag.
        sf_flag_d = (state_d == S_SF) && (len_of(gr_d, ch_d, p23_q) != '0);
        hf_flag_d = (state_d == S_HF);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            // NOTE: the latched side-info registers are reset too, so a reset mid-frame leaves nothing stale.
            mdb_q        <= '0;
            p23_q        <= '0;
            mono_q       <= 1'b0;
            lsf_q        <= 1'b0;
            discard_q    <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            gr_q         <= '0;
            ch_q         <= '0;
            sf_flag_q    <= 1'b0;
            hf_flag_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            mdb_q        <= mdb_d;
            p23_q        <= p23_d;
            mono_q       <= mono_d;
            lsf_q        <= lsf_d;
            discard_q    <= discard_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            gr_q         <= gr_d;
            ch_q         <= ch_d;
            sf_flag_q    <= sf_flag_d;
            hf_flag_q    <= hf_flag_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign sf_flag    = sf_flag_q;
    assign hf_flag    = hf_flag_q;
    assign gr         = gr_q;
    assign ch         = ch_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_main_data_router.sv
// Directed bench for main_data_router: a bench-side scalefactor parser model
// pulses sf_done after a set bit count; bit tallies are checked per frame.
module tb_main_data_router;

    localparam int NGR = 2, NCH = 2, LEN_W = 12, CNT_W = 16, BEGIN_W = 9;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       si_valid;
    logic [BEGIN_W-1:0]         main_data_begin;
    logic [NGR*NCH*LEN_W-1:0]   part2_3_length;
    logic                       mono, lsf;
    logic [CNT_W-1:0]           fifo_count;
    logic                       fifo_dout_v;
    logic                       sf_done;
    logic                       fifo_rd, sf_flag, hf_flag, frame_done;
    logic [0:0]                 gr, ch;
    logic [2:0]                 err;

    main_data_router #(
        .NGR(NGR), .NCH(NCH), .LEN_W(LEN_W), .CNT_W(CNT_W), .BEGIN_W(BEGIN_W)
    ) dut (
        .clk(clk), .rst(rst), .si_valid(si_valid),
        .main_data_begin(main_data_begin), .part2_3_length(part2_3_length),
        .mono(mono), .lsf(lsf), .fifo_count(fifo_count),
        .fifo_dout_v(fifo_dout_v), .sf_done(sf_done),
        .fifo_rd(fifo_rd), .sf_flag(sf_flag), .hf_flag(hf_flag),
        .gr(gr), .ch(ch), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-frame observations
    int         sf_bits, hf_bits, disc_bits, done_cnt, nent, hf00, first_sf_k, cyc;
    int         sf_cnt, sf_target;
    logic       sf_done_nx, have_gc, any_gc1;
    logic [7:0] seq;
    logic [1:0] last_gc, first_gc;

    task automatic clear_stats();
        sf_bits = 0; hf_bits = 0; disc_bits = 0; done_cnt = 0; nent = 0;
        hf00 = 0; first_sf_k = -1; cyc = 0; sf_cnt = 0;
        sf_done_nx = 1'b0; have_gc = 1'b0; any_gc1 = 1'b0;
        seq = 8'h00; last_gc = 2'b00; first_gc = 2'b11;
    endtask

    // Called at posedge+1: drive this cycle's inputs, sample, then advance one clock.
    task automatic run_cycle(input logic si, input logic dv);
        si_valid    = si;
        fifo_dout_v = dv;
        sf_done     = sf_done_nx;
        sf_done_nx  = 1'b0;
        #2;
        if (fifo_rd && fifo_dout_v) begin
            if (sf_flag) begin
                sf_bits++;
                sf_cnt++;
                if (sf_cnt == sf_target) begin
                    sf_done_nx = 1'b1;
                    sf_cnt     = 0;
                end
            end else if (hf_flag) begin
                hf_bits++;
            end else begin
                disc_bits++;
            end
        end
        if (sf_flag || hf_flag) begin
            if (!have_gc || {gr, ch} != last_gc) begin
                seq     = {seq[5:0], gr, ch};
                nent++;
                last_gc = {gr, ch};
                have_gc = 1'b1;
            end
            if (sf_flag && first_sf_k < 0) begin
                first_sf_k = cyc;
                first_gc   = {gr, ch};
            end
            if (hf_flag && gr == 1'b0 && ch == 1'b0) hf00++;
        end
        if (cyc >= 1 && (gr != 1'b0 || ch != 1'b0)) any_gc1 = 1'b1;
        if (frame_done) done_cnt++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [BEGIN_W-1:0] mdb, input logic [NGR*NCH*LEN_W-1:0] lens,
                             input logic mn, input logic ls, input logic [CNT_W-1:0] cnt,
                             input int tgt, input logic gap, input logic inject);
        clear_stats();
        main_data_begin = mdb;
        part2_3_length  = lens;
        mono            = mn;
        lsf             = ls;
        fifo_count      = cnt;
        sf_target       = tgt;
        for (int k = 0; k < 3000; k++) begin
            run_cycle((k == 0) || (inject && k == 10), gap ? (k % 5 != 4) : 1'b1);
            if (done_cnt > 0) break;
        end
        // A few idle cycles catch a second frame_done or stray consumption.
        repeat (3) run_cycle(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        si_valid = 1'b0; main_data_begin = '0; part2_3_length = '0;
        mono = 1'b0; lsf = 1'b0; fifo_count = '0; fifo_dout_v = 1'b0; sf_done = 1'b0;
        sf_target = 0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_sf_flag", sf_flag, 0);
        check("rst_hf_flag", hf_flag, 0);
        check("rst_gr_ch", {gr, ch}, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Stereo, no reservoir, all lengths 100, parser done after 40 bits, gappy FIFO.
        run_frame(9'd0, {4{12'd100}}, 1'b0, 1'b0, 16'd0, 40, 1'b1, 1'b0);
        check("t1_sf_bits", sf_bits, 160);
        check("t1_hf_bits", hf_bits, 240);
        check("t1_disc_bits", disc_bits, 0);
        check("t1_seq", seq, 8'h1B);
        check("t1_nent", nent, 4);
        check("t1_done", done_cnt, 1);
        check("t1_err", err, 0);
        check("t1_sf_start", first_sf_k, 2);

        // 50 bits held, begin 3 bytes: 26 stale bits dropped.
        run_frame(9'd3, {36'd0, 12'd20}, 1'b1, 1'b1, 16'd50, 20, 1'b0, 1'b0);
        check("t2_disc_bits", disc_bits, 26);
        check("t2_sf_start", first_sf_k, 28);
        check("t2_first_gc", first_gc, 0);
        check("t2_sf_bits", sf_bits, 20);
        check("t2_err", err, 0);
        check("t2_done", done_cnt, 1);

        // Reservoir underflow: 10 bits held, 24 needed.
        run_frame(9'd3, {36'd0, 12'd20}, 1'b1, 1'b1, 16'd10, 20, 1'b0, 1'b0);
        check("t3_err", err, 1);
        check("t3_disc_bits", disc_bits, 0);
        check("t3_sf_start", first_sf_k, 2);
        do_reset();

        // Scalefactor overrun on (0,0); (0,1) runs 40 sf + 10 hf.
        run_frame(9'd0, {24'd0, 12'd50, 12'd30}, 1'b0, 1'b1, 16'd0, 40, 1'b1, 1'b0);
        check("t4_err", err, 2);
        check("t4_hf00", hf00, 0);
        check("t4_sf_bits", sf_bits, 80);
        check("t4_hf_bits", hf_bits, 10);
        check("t4_seq", seq[3:0], 4'b0001);
        check("t4_nent", nent, 2);
        check("t4_done", done_cnt, 1);
        do_reset();

        // Mono + LSF: one entry only.
        run_frame(9'd0, {36'd0, 12'd20}, 1'b1, 1'b1, 16'd0, 20, 1'b1, 1'b0);
        check("t5_sf_bits", sf_bits, 20);
        check("t5_hf_bits", hf_bits, 0);
        check("t5_nent", nent, 1);
        check("t5_gc_one", any_gc1, 0);
        check("t5_done", done_cnt, 1);
        check("t5_err", err, 0);

        // si_valid during SF: flagged, frame unaffected.
        run_frame(9'd0, {4{12'd100}}, 1'b0, 1'b0, 16'd0, 40, 1'b1, 1'b1);
        check("t6_err", err, 4);
        check("t6_sf_bits", sf_bits, 160);
        check("t6_hf_bits", hf_bits, 240);
        check("t6_done", done_cnt, 1);

        // Asynchronous reset in the middle of HF with a toggling FIFO.
        clear_stats();
        main_data_begin = '0; part2_3_length = {4{12'd100}};
        mono = 1'b0; lsf = 1'b0; fifo_count = '0; sf_target = 40;
        for (int k = 0; k < 400; k++) begin
            run_cycle(k == 0, k[0]);
            if (hf_bits >= 3) break;
        end
        check("t7_reach_hf", int'(hf_bits >= 3), 1);
        sf_done = 1'b0;
        fifo_dout_v = 1'b1;
        #2;
        check("t7_rd_pre", fifo_rd, 1);
        check("t7_hf_pre", hf_flag, 1);
        rst = 1'b1;
        #1;
        check("t7_rd_rst", fifo_rd, 0);
        check("t7_hf_rst", hf_flag, 0);
        check("t7_err_rst", err, 0);
        check("t7_gc_rst", {gr, ch}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
        repeat (10) run_cycle(1'b0, 1'b1);
        check("t7_idle_bits", disc_bits + sf_bits + hf_bits, 0);
        check("t7_idle_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
